// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
// Holds the frame FSM state encoding, data width and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

  localparam int UART_DATA_BITS = 8;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr,
// wrapping at N. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    int j;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any       = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX line among NUM_REQ byte producers: round-robin pick in
// IDLE, then a registered start/data/parity/stop frame sequencer.
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       frame_done
);
  import uart_pkg::*;

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

  // Handshake: a byte moves when req_valid[i] & req_ready[i] on a rising edge.
  // req_ready is one-hot, only in IDLE, and forced low while reset is high.

  uart_tx_state_t state, state_next;
  logic [BW-1:0]  baud, baud_next;
  logic [2:0]     bit_cnt, bit_next;
  logic [7:0]     shift, shift_next;
  logic           par_bit, par_next;
  logic [IW-1:0]  ptr, ptr_next;
  logic [IW-1:0]  grant_next;
  logic           tx_next;
  logic           bit_end;

  logic [NUM_REQ-1:0] win_onehot;
  logic [IW-1:0]      win_idx;
  logic               win_any;
  logic [7:0]         req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (win_onehot),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  assign bit_end    = (baud == BAUD_LAST);
  assign busy       = (state != IDLE);
  assign frame_done = (state == STOP) && bit_end;
  assign req_ready  = (state == IDLE && !reset) ? win_onehot : '0;

  always_comb begin
    state_next = state;
    baud_next  = baud;
    bit_next   = bit_cnt;
    shift_next = shift;
    par_next   = par_bit;
    ptr_next   = ptr;
    grant_next = grant_id;
    tx_next    = 1'b1;
    case (state)
      IDLE: begin
        if (win_any) begin
          shift_next = req_bytes[win_idx];
          par_next   = even_parity(req_bytes[win_idx]);
          grant_next = win_idx;
          ptr_next   = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
          baud_next  = '0;
          bit_next   = '0;
          state_next = START;
        end
      end
      START: begin
        baud_next = bit_end ? '0 : baud + BW'(1);
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        baud_next = bit_end ? '0 : baud + BW'(1);
        if (bit_end) begin
          if (bit_cnt == BIT_LAST) begin
            state_next = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_next   = bit_cnt + 3'd1;
            shift_next = {1'b0, shift[7:1]};
          end
        end
      end
      PARITY: begin
        baud_next = bit_end ? '0 : baud + BW'(1);
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        baud_next = bit_end ? '0 : baud + BW'(1);
        if (bit_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // tx is registered, so decode it from the state being entered.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = par_next;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud     <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      ptr      <= '0;
      grant_id <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      baud     <= baud_next;
      bit_cnt  <= bit_next;
      shift    <= shift_next;
      par_bit  <= par_next;
      ptr      <= ptr_next;
      grant_id <= grant_next;
      tx       <= tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: expected grants/bytes are queued when
// requests are driven, and a monitor pops them and checks every frame cycle.
module tb_uart_tx_scheduler;
  localparam int NR  = 4;
  localparam int CPB = 4;

  logic          clk, reset;
  logic [NR-1:0] req_valid, req_ready;
  logic [8*NR-1:0] req_data;
  logic          tx, busy, frame_done;
  logic [1:0]    grant_id;

  logic [NR-1:0] np_valid, np_ready;
  logic [8*NR-1:0] np_data;
  logic          np_tx, np_busy, np_done;
  logic [1:0]    np_grant;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];
  logic [9:0] ent;
  bit         mon_active = 0;
  bit         expect_b2b = 0;
  int         mon_cyc = 0;
  int         grant_cnt = 0;
  int         idle_cnt = 0;
  logic [7:0] mon_byte;
  logic [1:0] mon_grant;

  uart_tx_scheduler #(.NUM_REQ(NR), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx(tx), .busy(busy), .grant_id(grant_id),
    .frame_done(frame_done)
  );

  uart_tx_scheduler #(.NUM_REQ(NR), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut_np (
    .clk(clk), .reset(reset), .req_valid(np_valid), .req_data(np_data),
    .req_ready(np_ready), .tx(np_tx), .busy(np_busy), .grant_id(np_grant),
    .frame_done(np_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx, input bit par);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9 && par) return ^b;
    return 1'b1;
  endfunction

  function automatic int onehot_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grants(input int target);
    int n;
    n = 0;
    while (grant_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("grant_timeout", grant_cnt >= target, 1);
    tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    check("idle_timeout", busy, 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      mon_active = 0;
    end else if (mon_active) begin
      mon_cyc++;
      check("frame_tx", tx, frame_bit(mon_byte, (mon_cyc - 1) / CPB, 1'b1));
      check("frame_done", frame_done, mon_cyc == 11 * CPB);
      check("frame_busy", busy, 1);
      check("frame_ready", req_ready, 0);
      if (mon_cyc == 1) check("grant_id", grant_id, mon_grant);
      if (mon_cyc == 11 * CPB) begin
        mon_active = 0;
        idle_cnt   = 0;
      end
    end else begin
      idle_cnt++;
      check("idle_tx", tx, 1);
      check("idle_done", frame_done, 0);
      check("idle_busy", busy, 0);
      if (|(req_valid & req_ready)) begin
        check("ready_onehot", $countones(req_ready), 1);
        if (expect_b2b) check("b2b_gap", idle_cnt, 1);
        check("exp_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          ent = exp_q.pop_front();
          check("grant_idx", onehot_idx(req_ready), ent[9:8]);
          check("grant_byte", req_data[8*onehot_idx(req_ready) +: 8], ent[7:0]);
          mon_byte  = ent[7:0];
          mon_grant = ent[9:8];
        end
        grant_cnt++;
        mon_active = 1;
        mon_cyc    = 0;
      end
    end
  end

  initial begin
    int base;
    int n;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    np_valid  = '0;
    np_data   = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_done", frame_done, 0);
    check("rst_grant", grant_id, 0);
    check("rst_np_tx", np_tx, 1);
    tick();
    reset = 1'b0;

    // idle: monitor checks tx/busy/frame_done every cycle
    repeat (100) tick();
    check("idle_ready", req_ready, 0);

    // single byte A5 from requester 1
    exp_q.push_back({2'd1, 8'hA5});
    req_data[15:8] = 8'hA5;
    req_valid[1]   = 1'b1;
    wait_grants(1);
    req_valid[1] = 1'b0;
    wait_idle();
    check("single_grant_hold", grant_id, 1);

    // contention from a fresh pointer
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    base = grant_cnt;
    req_data = {8'h33, 8'h22, 8'h11, 8'h00};
    exp_q.push_back({2'd0, 8'h00});
    exp_q.push_back({2'd1, 8'h11});
    exp_q.push_back({2'd2, 8'h22});
    exp_q.push_back({2'd3, 8'h33});
    exp_q.push_back({2'd0, 8'h00});
    req_valid = 4'b1111;
    wait_grants(base + 1);
    expect_b2b = 1;
    wait_grants(base + 5);
    req_valid  = '0;
    expect_b2b = 0;
    wait_idle();

    // fairness: req2 arrives mid-frame of req0
    base = grant_cnt;
    req_data = '0;
    req_data[7:0]   = 8'h5A;
    req_data[23:16] = 8'hC3;
    exp_q.push_back({2'd0, 8'h5A});
    exp_q.push_back({2'd2, 8'hC3});
    exp_q.push_back({2'd0, 8'h5A});
    req_valid[0] = 1'b1;
    wait_grants(base + 1);
    repeat (20) tick();
    req_valid[2] = 1'b1;
    wait_grants(base + 2);
    req_valid[2] = 1'b0;
    wait_grants(base + 3);
    req_valid[0] = 1'b0;
    wait_idle();

    // reset during data bit 3, then req3 gets a fresh frame
    base = grant_cnt;
    req_data[15:8] = 8'hF0;
    exp_q.push_back({2'd1, 8'hF0});
    req_valid[1] = 1'b1;
    wait_grants(base + 1);
    req_valid[1] = 1'b0;
    repeat (17) tick();
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    req_data[31:24] = 8'h3C;
    req_valid[3]    = 1'b1;
    tick();
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_ready", req_ready, 0);
    tick();
    check("midrst_ready2", req_ready, 0);
    exp_q.push_back({2'd3, 8'h3C});
    reset = 1'b0;
    wait_grants(base + 2);
    req_valid[3] = 1'b0;
    wait_idle();
    check("after_rst_grant", grant_id, 3);

    // parity disabled instance, byte 07
    np_data[7:0] = 8'h07;
    np_valid[0]  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!np_ready[0] && n < 50);
    check("np_ready", np_ready, 4'b0001);
    tick();
    np_valid[0] = 1'b0;
    for (int c = 1; c <= 10 * CPB; c++) begin
      @(negedge clk);
      check("np_tx", np_tx, frame_bit(8'h07, (c - 1) / CPB, 1'b0));
      check("np_done", np_done, c == 10 * CPB);
    end
    @(negedge clk);
    check("np_busy_end", np_busy, 0);
    check("np_tx_end", np_tx, 1);
    check("np_grant", np_grant, 0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
